// File: rtl/adc_stream_pkg.sv
// Shared constants for the ADC stream path: word field layout, counter widths, packer states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_stream_pkg;

  // Header word: {flag, tag, num_ch-1, drop count, sequence}
  localparam logic [2:0] HDR_TAG      = 3'b010;
  localparam int         HDR_FLAG_BIT = 31;
  localparam int         HDR_TAG_LSB  = 28;
  localparam int         HDR_NCH_LSB  = 24;
  localparam int         HDR_DROP_LSB = 16;
  localparam int         HDR_SEQ_LSB  = 0;

  // Data word: {flag=0, 3'b000, channel index, sign-extended sample}
  localparam int DAT_CH_LSB  = 24;
  localparam int DAT_SMP_LSB = 0;
  localparam int DAT_SMP_W   = 24;

  localparam int DROP_HDR_W = 8;
  localparam int SEQ_W      = 16;
  localparam int DROP_TOT_W = 16;

  // Packer FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

endpackage

// File: rtl/adc_frame_packer_if.sv
// Word push channel from the frame packer into the ADC stream FIFO.
// Latency: n/a (wires only).
// Backpressure: word transfers when push_valid & push_ready; producer holds data while stalled.
interface adc_frame_packer_if;
  logic        push_valid;
  logic [31:0] push_data;
  logic        push_ready;

  modport master (output push_valid, output push_data, input push_ready);
  modport slave  (input push_valid, input push_data, output push_ready);
endinterface

// File: rtl/adc_sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with inc loads 1.
// Latency: count updates one cycle after inc/clear.
// Backpressure: none; holds at all-ones once saturated.
module adc_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Clear wins over the old value but still counts an event in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/adc_frame_packer.sv
// Serialises one parallel ADC frame into a header word plus one word per channel for the stream FIFO.
// Latency: first word 1 cycle after an admitted strobe; then 1 word/cycle, back-to-back frames without a bubble.
// Backpressure: holds the current word while push_ready is low; frames without whole-frame FIFO room are dropped and counted.
module adc_frame_packer
  import adc_stream_pkg::*;
#(
  parameter  int NUM_CH     = 8,
  parameter  int SAMPLE_W   = 24,
  parameter  int FIFO_DEPTH = 64,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       frame_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0] frame_data,
  input  logic [LVL_W-1:0]           fifo_level,
  adc_frame_packer_if.master         push,
  output logic                       busy,
  output logic [DROP_TOT_W-1:0]      drop_total,
  input  logic                       drop_clear
);

  logic [1:0]                 state;
  logic [3:0]                 ch_idx;
  logic [NUM_CH*SAMPLE_W-1:0] frame_q;
  logic [SEQ_W-1:0]           seq_q;
  logic [DROP_HDR_W-1:0]      drop_hdr;

  logic                       hdr_acc, dat_acc, last_acc, space_ok, admit, drop;
  logic [3:0]                 nxt_idx;
  logic signed [SAMPLE_W-1:0] smp;
  logic [31:0]                hdr_word, data_word;

  // Admission decision and the next word to load into the push register
  always_comb begin
    hdr_acc  = (state == ST_HDR) && push.push_valid && push.push_ready;
    dat_acc  = (state == ST_DATA) && push.push_valid && push.push_ready;
    last_acc = dat_acc && (ch_idx == 4'(NUM_CH - 1));
    // The word leaving on a last-accept cycle is not yet counted in fifo_level, hence the +1.
    // Written as a sum so nothing can underflow.
    space_ok = (32'(fifo_level) + (last_acc ? 32'd1 : 32'd0) + 32'(NUM_CH + 1)) <= 32'(FIFO_DEPTH);
    admit    = frame_valid && enable && ((state == ST_IDLE) || last_acc) && space_ok;
    drop     = frame_valid && enable && !admit;

    nxt_idx  = hdr_acc ? 4'd0 : ch_idx + 4'd1;
    smp      = frame_q[int'(nxt_idx)*SAMPLE_W +: SAMPLE_W];

    hdr_word                               = '0;
    hdr_word[HDR_FLAG_BIT]                 = 1'b1;
    hdr_word[HDR_TAG_LSB +: 3]             = HDR_TAG;
    hdr_word[HDR_NCH_LSB +: 4]             = 4'(NUM_CH - 1);
    hdr_word[HDR_DROP_LSB +: DROP_HDR_W]   = drop_hdr;
    hdr_word[HDR_SEQ_LSB +: SEQ_W]         = seq_q;

    data_word                              = '0;
    data_word[DAT_CH_LSB +: 4]             = nxt_idx;
    data_word[DAT_SMP_LSB +: DAT_SMP_W]    = DAT_SMP_W'(smp);
  end

  // Frame FSM: owns the push register so a stalled word never changes under the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      ch_idx          <= '0;
      frame_q         <= '0;
      seq_q           <= '0;
      push.push_valid <= 1'b0;
      push.push_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (admit) begin
            state           <= ST_HDR;
            frame_q         <= frame_data;
            push.push_valid <= 1'b1;
            push.push_data  <= hdr_word;
          end
        end
        ST_HDR: begin
          if (hdr_acc) begin
            state          <= ST_DATA;
            ch_idx         <= '0;
            seq_q          <= seq_q + 1'b1;
            push.push_data <= data_word;
          end
        end
        ST_DATA: begin
          if (last_acc) begin
            if (admit) begin
              state          <= ST_HDR;
              frame_q        <= frame_data;
              push.push_data <= hdr_word;
            end else begin
              state           <= ST_IDLE;
              push.push_valid <= 1'b0;
            end
          end else if (dat_acc) begin
            ch_idx         <= ch_idx + 4'd1;
            push.push_data <= data_word;
          end
        end
        default: begin
          state           <= ST_IDLE;
          push.push_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

  // Drops since the last emitted header; reported in the next header
  adc_sat_counter #(.W(DROP_HDR_W)) u_drop_hdr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (hdr_acc),
    .inc   (drop),
    .count (drop_hdr)
  );

  // Firmware-visible running drop count
  adc_sat_counter #(.W(DROP_TOT_W)) u_drop_total (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (drop_clear),
    .inc   (drop),
    .count (drop_total)
  );

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer: a 4-channel/24-bit instance for most scenarios,
// a 2-channel/16-bit instance for sign extension. Outputs are sampled 1 time unit after
// the rising edge, inputs are changed at the same point.
module tb_adc_frame_packer;

  logic        clk;
  logic        rst_n;
  logic        enable;

  // 4-channel, 24-bit instance
  logic        fv4;
  logic [95:0] fd4;
  logic [6:0]  lvl4;
  logic        busy4;
  logic [15:0] drop4;
  logic        clr4;
  adc_frame_packer_if pif4 ();

  // 2-channel, 16-bit instance
  logic        fv2;
  logic [31:0] fd2;
  logic [6:0]  lvl2;
  logic        busy2;
  logic [15:0] drop2;
  logic        clr2;
  adc_frame_packer_if pif2 ();

  adc_frame_packer #(.NUM_CH(4), .SAMPLE_W(24), .FIFO_DEPTH(64)) u_dut4 (
    .clk (clk), .rst_n (rst_n), .enable (enable),
    .frame_valid (fv4), .frame_data (fd4), .fifo_level (lvl4),
    .push (pif4), .busy (busy4), .drop_total (drop4), .drop_clear (clr4)
  );

  adc_frame_packer #(.NUM_CH(2), .SAMPLE_W(16), .FIFO_DEPTH(64)) u_dut2 (
    .clk (clk), .rst_n (rst_n), .enable (enable),
    .frame_valid (fv2), .frame_data (fd2), .fifo_level (lvl2),
    .push (pif2), .busy (busy2), .drop_total (drop2), .drop_clear (clr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Samples 0x000001, 0x800000, 0x7FFFFF, 0x123456 on ch0..ch3 and their data words
  localparam logic [95:0] FRAME_A = {24'h123456, 24'h7FFFFF, 24'h800000, 24'h000001};
  logic [31:0] dat_w [4] = '{32'h00000001, 32'h01800000, 32'h027FFFFF, 32'h03123456};

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Strobe FRAME_A into the 4-channel DUT; header is expected on the cycle after
  task automatic strobe4();
    fv4 = 1'b1;
    fd4 = FRAME_A;
    tick();
    fv4 = 1'b0;
  endtask

  // Header is present now; check it, the four data words and the return to idle
  task automatic drain4(input string tag, input logic [31:0] hdr);
    check_vec({tag, "_hdr_vld"}, 32'(pif4.push_valid), 32'd1);
    check_vec({tag, "_hdr"}, pif4.push_data, hdr);
    tick();
    for (int k = 0; k < 4; k++) begin
      check_vec($sformatf("%s_ch%0d", tag, k), pif4.push_data, dat_w[k]);
      tick();
    end
    check_vec({tag, "_idle_vld"}, 32'(pif4.push_valid), 32'd0);
    check_vec({tag, "_idle_busy"}, 32'(busy4), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1;
    fv4 = 1'b0; fd4 = '0; lvl4 = '0; clr4 = 1'b0; pif4.push_ready = 1'b1;
    fv2 = 1'b0; fd2 = '0; lvl2 = '0; clr2 = 1'b0; pif2.push_ready = 1'b1;

    // Reset state
    reset_dut();
    check_vec("rst_vld",   32'(pif4.push_valid), 32'd0);
    check_vec("rst_data",  pif4.push_data,       32'd0);
    check_vec("rst_busy",  32'(busy4),           32'd0);
    check_vec("rst_drop",  32'(drop4),           32'd0);

    // Basic frame: latency 1, five consecutive words
    strobe4();
    drain4("basic", 32'hA3000000);

    // Sign extension on the 16-bit instance
    fv2 = 1'b1; fd2 = {16'h7FFF, 16'h8000};
    tick();
    fv2 = 1'b0;
    check_vec("sx_hdr", pif2.push_data, 32'hA1000000);
    tick();
    check_vec("sx_ch0", pif2.push_data, 32'h00FF8000);
    tick();
    check_vec("sx_ch1", pif2.push_data, 32'h01007FFF);
    tick();
    check_vec("sx_idle", 32'(pif2.push_valid), 32'd0);

    // Space check: 60 used leaves 4 < 5 free, frame dropped
    reset_dut();
    lvl4 = 7'd60;
    strobe4();
    check_vec("space_drop_vld",  32'(pif4.push_valid), 32'd0);
    check_vec("space_drop_cnt",  32'(drop4),           32'd1);
    lvl4 = 7'd0;
    strobe4();
    drain4("space_f2", 32'hA3010000);
    // Exactly NUM_CH+1 free is enough
    lvl4 = 7'd59;
    strobe4();
    lvl4 = 7'd0;
    drain4("space_f3", 32'hA3000001);

    // Backpressure: ready low for three cycles while ch1 is presented
    reset_dut();
    strobe4();
    check_vec("bp_hdr", pif4.push_data, 32'hA3000000);
    tick();
    check_vec("bp_ch0", pif4.push_data, dat_w[0]);
    tick();
    check_vec("bp_ch1", pif4.push_data, dat_w[1]);
    pif4.push_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_vec($sformatf("bp_hold_vld%0d", i), 32'(pif4.push_valid), 32'd1);
      check_vec($sformatf("bp_hold_dat%0d", i), pif4.push_data, dat_w[1]);
    end
    pif4.push_ready = 1'b1;
    tick();
    check_vec("bp_ch2", pif4.push_data, dat_w[2]);
    tick();
    check_vec("bp_ch3", pif4.push_data, dat_w[3]);
    tick();
    check_vec("bp_idle", 32'(pif4.push_valid), 32'd0);

    // Overlap: busy-time strobe dropped, last-accept strobe chained with no bubble
    reset_dut();
    strobe4();
    check_vec("ov_hdr", pif4.push_data, 32'hA3000000);
    tick();
    check_vec("ov_ch0", pif4.push_data, dat_w[0]);
    tick();
    check_vec("ov_ch1", pif4.push_data, dat_w[1]);
    fv4 = 1'b1;
    tick();
    fv4 = 1'b0;
    check_vec("ov_ch2", pif4.push_data, dat_w[2]);
    check_vec("ov_busy_drop", 32'(drop4), 32'd1);
    tick();
    check_vec("ov_ch3", pif4.push_data, dat_w[3]);
    fv4 = 1'b1;
    tick();
    fv4 = 1'b0;
    check_vec("ov_chain_busy", 32'(busy4),           32'd1);
    check_vec("ov_chain_vld",  32'(pif4.push_valid), 32'd1);
    check_vec("ov_chain_hdr",  pif4.push_data,       32'hA3010001);
    tick(); tick(); tick();
    tick();
    check_vec("ov2_ch3", pif4.push_data, dat_w[3]);
    // Last-accept with 59 used: 59+1 in flight leaves only 4 free, so drop
    lvl4 = 7'd59;
    fv4 = 1'b1;
    tick();
    fv4 = 1'b0;
    lvl4 = 7'd0;
    check_vec("ov_last_full_vld",  32'(pif4.push_valid), 32'd0);
    check_vec("ov_last_full_drop", 32'(drop4),           32'd2);

    // Saturation: 300 drops with FIFO full
    reset_dut();
    lvl4 = 7'd64;
    fv4  = 1'b1;
    fd4  = FRAME_A;
    repeat (300) tick();
    fv4  = 1'b0;
    check_vec("sat_total", 32'(drop4), 32'd300);
    lvl4 = 7'd0;
    strobe4();
    check_vec("sat_hdr", pif4.push_data, 32'hA3FF0000);
    tick();
    tick();
    check_vec("sat_ch1", pif4.push_data, dat_w[1]);
    // Clear coincident with a drop leaves one
    fv4  = 1'b1;
    clr4 = 1'b1;
    tick();
    fv4  = 1'b0;
    clr4 = 1'b0;
    check_vec("clr_drop", 32'(drop4), 32'd1);
    // Reset mid-DATA: push_valid falls without waiting for a clock
    rst_n = 1'b0;
    #1;
    check_vec("arst_vld",  32'(pif4.push_valid), 32'd0);
    check_vec("arst_busy", 32'(busy4),           32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    strobe4();
    drain4("post_rst", 32'hA3000000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
